inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
- Inverse of the SE immediate-extension block: packs instruction fields plus a 32-bit signed immediate into a 32-bit RV32I instruction word of the selected format.
- Writes each packed word into instruction memory at sequential word addresses.
- Used by the testbench/boot path to load programs into the single-cycle core's instruction memory without a precompiled hex file.
- Rejects immediates that are out of range or misaligned, and reports them through sticky error flags.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
BASE_ADDR, 0, word address of the first write after reset or start

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  restart pulse: clears pointer, count, full, err (honoured in IDLE only)
in_valid  in  1  field set presented
in_ready  out  1  block accepts a field set this cycle
type_SE  in  3  format: 000 I, 001 S, 011 B, 100 J, any other R
opcode  in  7  inst[6:0]
rd  in  5  destination register
funct3  in  3  funct3 field
rs1  in  5  source 1
rs2  in  5  source 2
funct7  in  7  funct7 field (R only)
imm  in  32  signed byte-offset immediate
mem_we  out  1  write strobe to instruction memory
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  packed instruction
mem_ready  in  1  memory accepts the write this cycle
count  out  ADDR_W+1  words written since reset/start
full  out  1  count == 2^ADDR_W
err  out  1  sticky: at least one field set rejected
err_code  out  2  first error: 00 none, 01 range, 10 misaligned

Behaviour:
- Reset (async, rst_n low) values:
  - state IDLE; mem_we 0; mem_addr BASE_ADDR; mem_wdata 0.
  - count 0; full 0; err 0; err_code 00.
  - Reset mid-write abandons the write with no count increment.
- States:
  - IDLE: in_ready = !full. A handshake is in_valid && in_ready.
  - WRITE: in_ready = 0; mem_we = 1.
- Handshake in IDLE with checks passing:
  - Register mem_wdata and go to WRITE.
  - mem_we rises in the cycle after acceptance, i.e. latency 1.
- WRITE:
  - mem_we, mem_addr and mem_wdata hold stable until mem_ready is sampled high.
  - On that edge: count += 1, mem_addr += 1 (mod 2^ADDR_W), return to IDLE.
  - mem_we drops to 0 on that edge; minimum spacing between writes is 2 cycles.
- Handshake in IDLE with a check failing:
  - The field set is consumed and dropped; no write; stay in IDLE.
  - err is set. err_code is loaded only if err was 0, so it records the first error.
- Immediate checks. Misalignment has priority over range.
  - I/S: imm[31:11] all equal (range -2048..2047).
  - B: imm[0] == 0 (else 10), and imm[31:12] all equal (range -4096..4094).
  - J: imm[0] == 0 (else 10), and imm[31:20] all equal (range ±1 MiB).
  - R: imm ignored; never errors.
- Packing, from MSB to LSB:
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - R: funct7, rs2, rs1, funct3, rd, opcode.
- Round-trip property:
  - Feeding mem_wdata back through SE with the same type_SE returns imm for I/S.
  - For B/J it returns imm >>> 1, because SE yields halfword units.
- Full:
  - full rises on the edge where count reaches 2^ADDR_W.
  - in_ready stays 0 until start; mem_addr has wrapped to BASE_ADDR.
- start:
  - Acts only in IDLE: count 0, mem_addr BASE_ADDR, full 0, err 0, err_code 00.
  - start takes priority over a simultaneous handshake; that field set is not accepted and in_ready is forced 0 that cycle.
  - start in WRITE is ignored.

Test Plan:
- Reset, then I-type addi x1,x0,5 (opcode 0010011, funct3 000, imm 5), mem_ready tied 1 -> mem_we high one cycle after accept, mem_addr 0, mem_wdata 0x00500093, count 1.
- B-type beq x1,x2,imm -8 (opcode 1100011), mem_ready held 0 for 3 cycles -> mem_wdata 0xFE208CE3 stable while mem_we is high, in_ready 0 throughout, single count increment.
- J-type imm 3 -> no write, err 1, err_code 10. Then I-type imm 4096 -> err_code stays 10, count unchanged.
- Random legal fields for all five formats, each word decoded by SE -> imm (I/S) or imm>>>1 (B/J) matches. R word equals {funct7, rs2, rs1, funct3, rd, opcode}.
- ADDR_W=2: write 4 words -> full 1, in_ready 0, mem_addr back at 0. Pulse start together with in_valid -> count 0, full 0, no accept that cycle.
- Assert rst_n low while in WRITE -> mem_we 0 immediately (asynchronously), count 0, next accepted word written to BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder_loader_if.sv
// Field-set / instruction-memory bus for the instruction encoder-loader.
// The master side drives field sets and memory acceptance; the slave side
// is the encoder-loader itself.
interface inst_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        type_SE;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output start, in_valid, type_SE, opcode, rd, funct3, rs1, rs2, funct7, imm,
           mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err, err_code
  );

  modport slave (
    input  start, in_valid, type_SE, opcode, rd, funct3, rs1, rs2, funct7, imm,
           mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err, err_code
  );
endinterface

// File: rtl/inst_encoder_loader.sv
// Packs RV32I fields plus a signed byte-offset immediate into a 32-bit
// instruction word and writes it to instruction memory at sequential word
// addresses. Out-of-range or misaligned immediates are dropped and flagged
// through sticky error status (first error code is kept).
module inst_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_encoder_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  typedef enum logic [1:0] {
    E_NONE  = 2'b00,
    E_RANGE = 2'b01,
    E_ALIGN = 2'b10
  } err_t;

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b011,
    FMT_J = 3'b100
  } fmt_t;

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_err;
  err_t              r_err_code;

  logic [31:0]       w_packed;
  err_t              w_code;
  logic              w_in_ready;
  logic              w_mem_we;
  logic              w_accept;
  logic              w_full;
  logic              w_fit_is;
  logic              w_fit_b;
  logic              w_fit_j;
  logic [31:0]       w_imm;

  assign w_imm  = bus.imm;
  // count can only reach 2^ADDR_W, so its top bit alone marks full.
  assign w_full = r_count[ADDR_W];

  // Sign-extension checks: the bits above the encodable field must all match.
  assign w_fit_is = (&w_imm[31:11]) | ~(|w_imm[31:11]);
  assign w_fit_b  = (&w_imm[31:12]) | ~(|w_imm[31:12]);
  assign w_fit_j  = (&w_imm[31:20]) | ~(|w_imm[31:20]);

  // Format packing and immediate validation; misalignment outranks range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_code   = E_NONE;
    w_packed = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
    case (bus.type_SE)
      FMT_I: begin
        w_packed = {w_imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        if (!w_fit_is) w_code = E_RANGE;
      end
      FMT_S: begin
        w_packed = {w_imm[11:5], bus.rs2, bus.rs1, bus.funct3, w_imm[4:0],
                    bus.opcode};
        if (!w_fit_is) w_code = E_RANGE;
      end
      FMT_B: begin
        w_packed = {w_imm[12], w_imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                    w_imm[4:1], w_imm[11], bus.opcode};
        if (w_imm[0])     w_code = E_ALIGN;
        else if (!w_fit_b) w_code = E_RANGE;
      end
      FMT_J: begin
        w_packed = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.rd,
                    bus.opcode};
        if (w_imm[0])     w_code = E_ALIGN;
        else if (!w_fit_j) w_code = E_RANGE;
      end
      default: ;
    endcase
  end

  // FSM next-state and handshake/strobe outputs; start blocks acceptance.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_mem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = !w_full && !bus.start;
        if (w_in_ready && bus.in_valid && (w_code == E_NONE))
          w_next_state = S_WRITE;
      end
      S_WRITE: begin
        w_mem_we = 1'b1;
        if (bus.mem_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Datapath: restart, word capture, error capture, write completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= BASE;
      r_mem_wdata <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_err_code  <= E_NONE;
    end else if (r_state == S_IDLE && bus.start) begin
      r_mem_addr <= BASE;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_err_code <= E_NONE;
    end else if (w_accept) begin
      if (w_code == E_NONE) begin
        r_mem_wdata <= w_packed;
      end else begin
        r_err <= 1'b1;
        if (!r_err) r_err_code <= w_code;
      end
    end else if (r_state == S_WRITE && bus.mem_ready) begin
      r_count    <= r_count + CNT_ONE;
      r_mem_addr <= r_mem_addr + ADDR_ONE;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: one ADDR_W=8 instance for
// encoding/handshake/error/reset behaviour, one ADDR_W=2 instance for
// full and start handling.
module tb_inst_encoder_loader;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  inst_encoder_loader_if #(.ADDR_W(8)) bus_a ();
  inst_encoder_loader_if #(.ADDR_W(2)) bus_b ();

  inst_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference immediate extension (SE block) for round-trip decoding.
  function automatic logic [31:0] se(input logic [2:0] t, input logic [31:0] w);
    case (t)
      3'b000:  se = {{20{w[31]}}, w[31:20]};
      3'b001:  se = {{20{w[31]}}, w[31:25], w[11:7]};
      3'b011:  se = {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
      3'b100:  se = {{12{w[31]}}, w[31], w[19:12], w[20], w[30:21]};
      default: se = 32'd0;
    endcase
  endfunction

  task automatic drive_a(input logic [2:0] t, input logic [6:0] op,
                         input logic [4:0] rd_i, input logic [2:0] f3,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [6:0] f7, input logic [31:0] im);
    bus_a.type_SE = t;
    bus_a.opcode  = op;
    bus_a.rd      = rd_i;
    bus_a.funct3  = f3;
    bus_a.rs1     = r1;
    bus_a.rs2     = r2;
    bus_a.funct7  = f7;
    bus_a.imm     = im;
  endtask

  // One accepted field set with mem_ready high; returns the written word/address.
  task automatic write_a(input logic [2:0] t, input logic [6:0] op,
                         input logic [4:0] rd_i, input logic [2:0] f3,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [6:0] f7, input logic [31:0] im,
                         output logic [31:0] word, output logic [7:0] addr);
    int n;
    drive_a(t, op, rd_i, f3, r1, r2, f7, im);
    bus_a.in_valid = 1'b1;
    step();
    bus_a.in_valid = 1'b0;
    n = 0;
    while (bus_a.mem_we !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check("write_strobe", {31'd0, bus_a.mem_we}, 32'd1);
    word = bus_a.mem_wdata;
    addr = bus_a.mem_addr;
    step();
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  a;

    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.in_valid = 1'b0; bus_a.mem_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.in_valid = 1'b0; bus_b.mem_ready = 1'b1;
    drive_a(3'b000, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    bus_b.type_SE = 3'b000; bus_b.opcode = 7'b0010011; bus_b.rd = 5'd0;
    bus_b.funct3 = 3'd0; bus_b.rs1 = 5'd0; bus_b.rs2 = 5'd0;
    bus_b.funct7 = 7'd0; bus_b.imm = 32'd0;
    #12 rst_n = 1'b1;
    step();

    // Reset state.
    check("rst_we",       {31'd0, bus_a.mem_we},   32'd0);
    check("rst_addr",     {24'd0, bus_a.mem_addr}, 32'd0);
    check("rst_wdata",    bus_a.mem_wdata,         32'd0);
    check("rst_count",    {23'd0, bus_a.count},    32'd0);
    check("rst_full",     {31'd0, bus_a.full},     32'd0);
    check("rst_err",      {31'd0, bus_a.err},      32'd0);
    check("rst_err_code", {30'd0, bus_a.err_code}, 32'd0);
    check("rst_in_ready", {31'd0, bus_a.in_ready}, 32'd1);

    // addi x1,x0,5 with mem_ready tied high: write one cycle after accept.
    drive_a(3'b000, 7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd5);
    bus_a.in_valid = 1'b1;
    step();
    bus_a.in_valid = 1'b0;
    check("addi_we",       {31'd0, bus_a.mem_we},   32'd1);
    check("addi_addr",     {24'd0, bus_a.mem_addr}, 32'd0);
    check("addi_wdata",    bus_a.mem_wdata,         32'h0050_0093);
    check("addi_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
    step();
    check("addi_we_drop",  {31'd0, bus_a.mem_we},   32'd0);
    check("addi_count",    {23'd0, bus_a.count},    32'd1);
    check("addi_addr_inc", {24'd0, bus_a.mem_addr}, 32'd1);

    // beq x1,x2,-8 with memory stalled: outputs hold, single count increment.
    bus_a.mem_ready = 1'b0;
    drive_a(3'b011, 7'b1100011, 5'd0, 3'b000, 5'd1, 5'd2, 7'd0, -32'sd8);
    bus_a.in_valid = 1'b1;
    step();
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("beq_we",       {31'd0, bus_a.mem_we},   32'd1);
      check("beq_wdata",    bus_a.mem_wdata,         32'hFE20_8CE3);
      check("beq_addr",     {24'd0, bus_a.mem_addr}, 32'd1);
      check("beq_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
      check("beq_count",    {23'd0, bus_a.count},    32'd1);
      step();
    end
    bus_a.mem_ready = 1'b1;
    step();
    check("beq_we_drop", {31'd0, bus_a.mem_we}, 32'd0);
    check("beq_count2",  {23'd0, bus_a.count},  32'd2);

    // Misaligned J (imm 3) then out-of-range I (4096): first error sticks.
    drive_a(3'b100, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
    bus_a.in_valid = 1'b1;
    step();
    bus_a.in_valid = 1'b0;
    check("jmis_we",       {31'd0, bus_a.mem_we},   32'd0);
    check("jmis_err",      {31'd0, bus_a.err},      32'd1);
    check("jmis_err_code", {30'd0, bus_a.err_code}, 32'd2);
    check("jmis_count",    {23'd0, bus_a.count},    32'd2);
    check("jmis_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
    drive_a(3'b000, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4096);
    bus_a.in_valid = 1'b1;
    step();
    bus_a.in_valid = 1'b0;
    check("irng_we",       {31'd0, bus_a.mem_we},   32'd0);
    check("irng_err_code", {30'd0, bus_a.err_code}, 32'd2);
    check("irng_count",    {23'd0, bus_a.count},    32'd2);
    drive_a(3'b011, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd4096);
    bus_a.in_valid = 1'b1;
    step();
    bus_a.in_valid = 1'b0;
    check("brng_we",    {31'd0, bus_a.mem_we}, 32'd0);
    check("brng_count", {23'd0, bus_a.count},  32'd2);

    // Boundary-legal words in every format, round-tripped through SE.
    write_a(3'b000, 7'b0000011, 5'd5, 3'b010, 5'd6, 5'd0, 7'd0, -32'sd2048, w, a);
    check("lw_word",  w, 32'h8003_2283);
    check("lw_se",    se(3'b000, w), -32'sd2048);
    check("lw_addr",  {24'd0, a}, 32'd2);
    write_a(3'b001, 7'b0100011, 5'd0, 3'b010, 5'd7, 5'd9, 7'd0, 32'd2047, w, a);
    check("sw_se",    se(3'b001, w), 32'd2047);
    write_a(3'b011, 7'b1100011, 5'd0, 3'b001, 5'd3, 5'd4, 7'd0, 32'd4094, w, a);
    check("bpos_se",  se(3'b011, w), 32'd2047);
    write_a(3'b011, 7'b1100011, 5'd0, 3'b100, 5'd8, 5'd10, 7'd0, -32'sd4096, w, a);
    check("bneg_se",  se(3'b011, w), -32'sd2048);
    write_a(3'b100, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1048574, w, a);
    check("jpos_se",  se(3'b100, w), 32'd524287);
    write_a(3'b100, 7'b1101111, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, -32'sd1048576, w, a);
    check("jneg_se",  se(3'b100, w), -32'sd524288);
    write_a(3'b111, 7'b0110011, 5'd1, 3'b000, 5'd2, 5'd3, 7'b0100000, 32'hDEAD_BEEF, w, a);
    check("r_word",   w, 32'h4031_00B3);
    check("r_addr",   {24'd0, a}, 32'd8);
    check("seq_count", {23'd0, bus_a.count}, 32'd9);

    // Reset while a write is stalled: strobe drops asynchronously.
    bus_a.mem_ready = 1'b0;
    drive_a(3'b000, 7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7);
    bus_a.in_valid = 1'b1;
    step();
    bus_a.in_valid = 1'b0;
    check("mid_we", {31'd0, bus_a.mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_we",    {31'd0, bus_a.mem_we},   32'd0);
    check("async_count", {23'd0, bus_a.count},    32'd0);
    check("async_addr",  {24'd0, bus_a.mem_addr}, 32'd0);
    #2 rst_n = 1'b1;
    step();
    bus_a.mem_ready = 1'b1;
    write_a(3'b000, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, w, a);
    check("post_rst_addr",  {24'd0, a}, 32'd0);
    check("post_rst_word",  w, 32'h0050_0093);
    check("post_rst_count", {23'd0, bus_a.count}, 32'd1);

    // ADDR_W=2 instance: fill all four words.
    for (int i = 0; i < 4; i++) begin
      bus_b.in_valid = 1'b1;
      step();
      bus_b.in_valid = 1'b0;
      step();
    end
    check("full_count",    {29'd0, bus_b.count},    32'd4);
    check("full_flag",     {31'd0, bus_b.full},     32'd1);
    check("full_in_ready", {31'd0, bus_b.in_ready}, 32'd0);
    check("full_addr",     {30'd0, bus_b.mem_addr}, 32'd0);
    check("full_we",       {31'd0, bus_b.mem_we},   32'd0);

    // start with a field set while full: clears status, no accept.
    bus_b.start = 1'b1;
    bus_b.in_valid = 1'b1;
    #1;
    check("start_in_ready", {31'd0, bus_b.in_ready}, 32'd0);
    step();
    bus_b.start = 1'b0;
    bus_b.in_valid = 1'b0;
    check("start_count", {29'd0, bus_b.count},  32'd0);
    check("start_full",  {31'd0, bus_b.full},   32'd0);
    check("start_we",    {31'd0, bus_b.mem_we}, 32'd0);

    // start with a field set while not full: start still wins.
    bus_b.start = 1'b1;
    bus_b.in_valid = 1'b1;
    #1;
    check("start2_in_ready", {31'd0, bus_b.in_ready}, 32'd0);
    step();
    bus_b.start = 1'b0;
    bus_b.in_valid = 1'b0;
    check("start2_we",    {31'd0, bus_b.mem_we}, 32'd0);
    check("start2_count", {29'd0, bus_b.count},  32'd0);

    // Next accepted word goes to the base address.
    bus_b.in_valid = 1'b1;
    step();
    bus_b.in_valid = 1'b0;
    check("restart_we",   {31'd0, bus_b.mem_we},   32'd1);
    check("restart_addr", {30'd0, bus_b.mem_addr}, 32'd0);
    step();
    check("restart_count", {29'd0, bus_b.count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
